// File: rtl/instruction_fetch_mem.sv
// Instruction memory with a one-cycle registered fetch, RV32I field/immediate decode,
// valid/ready handshakes, fault flagging and a fetch counter. Optional macro: IMEM_PROG_PORT_EN.
module instruction_fetch_mem #(
  parameter int    DEPTH     = 128,
  parameter int    ADDR_W    = 32,
  parameter string INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               instruction,
  output logic [6:0]                opcode,
  output logic [4:0]                wa,
  output logic [4:0]                ra,
  output logic [4:0]                rb,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [31:0]               imm,
  output logic                      fault,
  output logic [31:0]               fetch_count
`ifdef IMEM_PROG_PORT_EN
  ,
  input  logic                      prog_we,
  input  logic [$clog2(DEPTH)-1:0]  prog_addr,
  input  logic [31:0]               prog_data
`endif
);

  localparam int         IDX_W     = $clog2(DEPTH);
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [31:0] r_mem [DEPTH];

`ifdef IMEM_PROG_PORT_EN
  // Not reset on purpose: programming is allowed while the fetch path is in reset.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
  end
`endif

  logic             r_rsp_valid;
  logic [31:0]      r_instruction;
  logic [6:0]       r_opcode;
  logic [4:0]       r_wa;
  logic [4:0]       r_ra;
  logic [4:0]       r_rb;
  logic [2:0]       r_funct3;
  logic [6:0]       r_funct7;
  logic [31:0]      r_imm;
  logic             r_fault;
  logic [31:0]      r_fetch_count;

  logic             w_accept;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic             w_fault;
  logic [IDX_W-1:0] w_index;
  logic [31:0]      w_word;
  logic [4:0]       w_wa;
  logic [4:0]       w_ra;
  logic [4:0]       w_rb;
  logic [31:0]      w_imm;

  assign req_ready      = !r_rsp_valid || rsp_ready;
  assign w_accept       = req_valid && req_ready;
  assign w_misaligned   = req_addr[1:0] != 2'b00;
  assign w_out_of_range = (req_addr >> (IDX_W + 2)) != '0;
  assign w_fault        = w_misaligned || w_out_of_range;
  assign w_index        = req_addr[IDX_W+1:2];
  // A faulting fetch substitutes a NOP so the decode below naturally yields its fields.
  assign w_word         = w_fault ? NOP : r_mem[w_index];

  always_comb begin
    w_wa  = '0;
    w_ra  = '0;
    w_rb  = '0;
    w_imm = '0;
    case (w_word[6:0])
      OP_R: begin
        w_wa = w_word[11:7];
        w_ra = w_word[19:15];
        w_rb = w_word[24:20];
      end
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        w_wa  = w_word[11:7];
        w_ra  = w_word[19:15];
        w_imm = {{20{w_word[31]}}, w_word[31:20]};
      end
      OP_STORE: begin
        w_ra  = w_word[19:15];
        w_rb  = w_word[24:20];
        w_imm = {{20{w_word[31]}}, w_word[31:25], w_word[11:7]};
      end
      OP_BRANCH: begin
        w_ra  = w_word[19:15];
        w_rb  = w_word[24:20];
        w_imm = {{19{w_word[31]}}, w_word[31], w_word[7], w_word[30:25], w_word[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_wa  = w_word[11:7];
        w_imm = {w_word[31:12], 12'b0};
      end
      OP_JAL: begin
        w_wa  = w_word[11:7];
        w_imm = {{11{w_word[31]}}, w_word[31], w_word[19:12], w_word[20], w_word[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid   <= 1'b0;
      r_instruction <= '0;
      r_opcode      <= '0;
      r_wa          <= '0;
      r_ra          <= '0;
      r_rb          <= '0;
      r_funct3      <= '0;
      r_funct7      <= '0;
      r_imm         <= '0;
      r_fault       <= 1'b0;
      r_fetch_count <= '0;
    end else if (w_accept) begin
      r_rsp_valid   <= 1'b1;
      r_instruction <= w_word;
      r_opcode      <= w_word[6:0];
      r_wa          <= w_wa;
      r_ra          <= w_ra;
      r_rb          <= w_rb;
      r_funct3      <= w_word[14:12];
      r_funct7      <= w_word[31:25];
      r_imm         <= w_imm;
      r_fault       <= w_fault;
      r_fetch_count <= r_fetch_count + 32'd1;
    end else if (rsp_ready) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign instruction = r_instruction;
  assign opcode      = r_opcode;
  assign wa          = r_wa;
  assign ra          = r_ra;
  assign rb          = r_rb;
  assign funct3      = r_funct3;
  assign funct7      = r_funct7;
  assign imm         = r_imm;
  assign fault       = r_fault;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Scoreboard bench for instruction_fetch_mem: a driver pushes model responses into exp_q,
// a negedge monitor pops and compares whenever the DUT presents a response.
module tb_instruction_fetch_mem;

  localparam int DEPTH = 128;
  localparam int W     = 129;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [4:0]  wa;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        fault;
  logic [31:0] fetch_count;
`ifdef IMEM_PROG_PORT_EN
  logic        prog_we;
  logic [6:0]  prog_addr;
  logic [31:0] prog_data;
`endif

  instruction_fetch_mem #(.DEPTH(DEPTH), .ADDR_W(32), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .instruction(instruction), .opcode(opcode), .wa(wa), .ra(ra), .rb(rb),
    .funct3(funct3), .funct7(funct7), .imm(imm), .fault(fault), .fetch_count(fetch_count)
`ifdef IMEM_PROG_PORT_EN
    , .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
`endif
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference state ----------------
  logic [31:0]  mdl_mem [DEPTH];
  logic [W-1:0] exp_q [$];
  logic         m_valid;
  logic [31:0]  m_count;
  logic         exp_req_ready;
  logic         exp_rsp_valid;
  logic         mon_en;
  int           n_checks;
  int           n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response predicted from the ISA encoding rules using integer arithmetic.
  function automatic logic [W-1:0] model_rsp(input logic [31:0] addr, input logic [31:0] cnt);
    logic [31:0] w;
    logic [31:0] imm_v;
    logic [4:0]  wa_v, ra_v, rb_v;
    logic        flt;
    int          s;
    flt   = (addr % 4 != 0) || ({32'b0, addr} >= 64'(DEPTH * 4));
    w     = flt ? 32'h0000_0013 : mdl_mem[addr / 4];
    s     = w[31] ? 1 : 0;
    wa_v  = w[11:7];
    ra_v  = w[19:15];
    rb_v  = w[24:20];
    imm_v = 32'd0;
    case (w[6:0])
      7'h33: ;
      7'h13, 7'h03, 7'h67, 7'h73: begin
        rb_v  = 5'd0;
        imm_v = 32'(int'(w[31:20]) - s * 4096);
      end
      7'h23: begin
        wa_v  = 5'd0;
        imm_v = 32'(int'({w[31:25], w[11:7]}) - s * 4096);
      end
      7'h63: begin
        wa_v  = 5'd0;
        imm_v = 32'(int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - s * 4096);
      end
      7'h37, 7'h17: begin
        ra_v  = 5'd0;
        rb_v  = 5'd0;
        imm_v = w & 32'hFFFF_F000;
      end
      7'h6F: begin
        ra_v  = 5'd0;
        rb_v  = 5'd0;
        imm_v = 32'(int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - s * 1048576);
      end
      default: begin
        wa_v = 5'd0;
        ra_v = 5'd0;
        rb_v = 5'd0;
      end
    endcase
    return {w, w[6:0], wa_v, ra_v, rb_v, w[14:12], w[31:25], imm_v, flt, cnt};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case ($urandom_range(0, 11))
      0: op = 7'h33;  1: op = 7'h13;  2: op = 7'h03;  3: op = 7'h67;
      4: op = 7'h73;  5: op = 7'h23;  6: op = 7'h63;  7: op = 7'h37;
      8: op = 7'h17;  9: op = 7'h6F;  default: op = r[6:0];
    endcase
    return {r[31:7], op};
  endfunction

  // ---------------- driver ----------------
  // Starts just after a rising edge; drives one cycle of inputs and updates the model.
  task automatic cycle(input logic rv, input logic [31:0] a, input logic rr);
    logic acc;
    logic nxt;
`ifdef IMEM_PROG_PORT_EN
    logic        we_s;
    logic [6:0]  wa_s;
    logic [31:0] wd_s;
    we_s = prog_we; wa_s = prog_addr; wd_s = prog_data;
`endif
    req_valid     = rv;
    req_addr      = a;
    rsp_ready     = rr;
    exp_req_ready = !m_valid || rr;
    exp_rsp_valid = m_valid;
    acc           = rv && exp_req_ready;
    if (acc) begin
      m_count = m_count + 32'd1;
      exp_q.push_back(model_rsp(a, m_count));
    end
    nxt = acc ? 1'b1 : (rr ? 1'b0 : m_valid);
    @(negedge clk);
    @(posedge clk);
    #1;
    m_valid = nxt;
`ifdef IMEM_PROG_PORT_EN
    if (we_s) mdl_mem[wa_s] = wd_s;
`endif
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_req_ready});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_rsp_valid});
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got response %08h with empty queue", instruction);
        end else begin
          mon_e = exp_q[0];
          chk("instruction", instruction, mon_e[128:97]);
          chk("opcode", {25'b0, opcode}, {25'b0, mon_e[96:90]});
          chk("wa", {27'b0, wa}, {27'b0, mon_e[89:85]});
          chk("ra", {27'b0, ra}, {27'b0, mon_e[84:80]});
          chk("rb", {27'b0, rb}, {27'b0, mon_e[79:75]});
          chk("funct3", {29'b0, funct3}, {29'b0, mon_e[74:72]});
          chk("funct7", {25'b0, funct7}, {25'b0, mon_e[71:65]});
          chk("imm", imm, mon_e[64:33]);
          chk("fault", {31'b0, fault}, {31'b0, mon_e[32]});
          chk("fetch_count", fetch_count, mon_e[31:0]);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0; n_errors = 0; mon_en = 1'b0;
    m_valid = 1'b0; m_count = 32'd0;
    exp_req_ready = 1'b1; exp_rsp_valid = 1'b0;
    reset = 1'b0; req_valid = 1'b1; req_addr = 32'd0; rsp_ready = 1'b1;
`ifdef IMEM_PROG_PORT_EN
    prog_we = 1'b0; prog_addr = 7'd0; prog_data = 32'd0;
`endif
    #1;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = rand_word();
    mdl_mem[0] = 32'h0050_0093;
    mdl_mem[1] = 32'h0020_8033;
    mdl_mem[2] = 32'hFE11_2E23;
    for (int i = 0; i < DEPTH; i++) dut.r_mem[i] = mdl_mem[i];

    // Reset held with a pending request.
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_fetch_count", fetch_count, 32'd0);
    chk("reset_instruction", instruction, 32'd0);
    chk("reset_imm", imm, 32'd0);
    chk("reset_fault", {31'b0, fault}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; mon_en = 1'b1;

    // Directed words: addi, add, sw.
    cycle(1'b1, 32'h0, 1'b1);
    cycle(1'b1, 32'h4, 1'b1);
    cycle(1'b1, 32'h8, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    // Backpressure with a waiting request.
    cycle(1'b1, 32'hC, 1'b1);
    repeat (3) cycle(1'b1, 32'h10, 1'b0);
    cycle(1'b1, 32'h10, 1'b1);
    cycle(1'b1, 32'h14, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    // Fault and range boundaries.
    cycle(1'b1, 32'h2, 1'b1);
    cycle(1'b1, 32'h200, 1'b1);
    cycle(1'b1, 32'h1FC, 1'b1);
    cycle(1'b1, 32'h8000_0000, 1'b1);
    cycle(1'b1, 32'h1FF, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    // Streaming without bubbles.
    for (int i = 0; i < 10; i++) cycle(1'b1, 32'(i * 4), 1'b1);
    repeat (2) cycle(1'b0, 32'h0, 1'b1);

    // Counter wrap.
    force dut.r_fetch_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_fetch_count;
    m_count = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'(i * 4 + 16), 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

`ifdef IMEM_PROG_PORT_EN
    // Read-first on a same-cycle write, then the new word.
    prog_we = 1'b1; prog_addr = 7'd3; prog_data = 32'hDEAD_BEEF;
    cycle(1'b1, 32'hC, 1'b1);
    prog_we = 1'b0;
    cycle(1'b1, 32'hC, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
`endif

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      if (k <= 6)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (k == 7) a = 32'($urandom_range(0, DEPTH * 4 - 1)) | 32'd1;
      else if (k == 8) a = $urandom() | 32'h0000_0200;
      else             a = ($urandom_range(0, 1) == 1) ? 32'h1FC : 32'h200;
`ifdef IMEM_PROG_PORT_EN
      prog_we   = ($urandom_range(0, 7) == 0);
      prog_addr = 7'($urandom_range(0, DEPTH - 1));
      prog_data = rand_word();
`endif
      cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
    end
`ifdef IMEM_PROG_PORT_EN
    prog_we = 1'b0;
`endif
    repeat (2) cycle(1'b0, 32'h0, 1'b1);

    // Asynchronous reset while a response is held.
    cycle(1'b1, 32'h4, 1'b0);
    mon_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_reset_req_ready", {31'b0, req_ready}, 32'd1);
    exp_q.delete();
    m_valid = 1'b0;
    m_count = 32'd0;
    @(negedge clk);
    chk("async_reset_fetch_count", fetch_count, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1; mon_en = 1'b1;
    cycle(1'b1, 32'h0, 1'b1);
    cycle(1'b1, 32'h8, 1'b1);

    repeat (4) cycle(1'b0, 32'h0, 1'b1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
